// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

    typedef enum logic [1:0] {
        FF_OK       = 2'b00,
        FF_MISALIGN = 2'b01,
        FF_RANGE    = 2'b10
    } fetch_fault_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } imem_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_RV32I = 32'h00000013;

endpackage

// File: rtl/imem_fetch_port_ram.sv
// Byte-enabled single-write-port storage with a registered, enabled read port.
module imem_ram #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN/8-1:0]        be,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);

    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read only on accept so the word stays put while the response is held;
    // a same-edge write to that word is not seen (old data).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with valid/ready fetch, configurable latency, fault
// reporting, flush on redirect and a byte-enabled loader write port.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 256,
    parameter int unsigned     LAT       = 1,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_RV32I
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          resp_instr,
    output logic [XLEN-1:0]          resp_addr,
    output logic [1:0]               resp_fault,
    input  logic                     flush,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [3:0]               prog_be,
    input  logic [XLEN-1:0]          prog_wdata
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned WAIT_LAST = (LAT > 1) ? LAT - 2 : 0;

    imem_state_e     state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    fetch_fault_e    fault_q, fault_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] ram_rdata;
    logic            accept;

    imem_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (accept),
        .raddr (req_addr[AW+1:2]),
        .we    (prog_we),
        .waddr (prog_addr),
        .be    (prog_be),
        .wdata (prog_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        fault_d = FF_OK;
        if (req_addr[1:0] != 2'b00) begin
            fault_d = FF_MISALIGN;
        end else if (|req_addr[XLEN-1:AW+2]) begin
            fault_d = FF_RANGE;
        end
    end

    // A flush always frees the port, so a redirect target is taken even while
    // an older fetch is still waiting or stalled.
    always_comb begin
        req_ready = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE:    req_ready = 1'b1;
            RESP:    req_ready = resp_ready;
            default: req_ready = 1'b0;
        endcase
        if (flush) begin
            req_ready = 1'b1;
        end
        accept = req_valid && req_ready;

        case (state_q)
            WAIT: begin
                if (cnt_q == 3'(WAIT_LAST)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
        if (accept) begin
            state_d = (LAT > 1) ? WAIT : RESP;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            fault_q <= FF_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                fault_q <= fault_d;
            end
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_addr  = addr_q;
    assign resp_fault = fault_q;
    assign resp_instr = (fault_q == FF_OK) ? ram_rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: three instances (LAT 1, 4, 3) checked
// every cycle against a transaction-level model plus literal expectations.
module tb_imem_fetch_port;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [3:0]  prog_be;
    logic [31:0] prog_wdata;

    logic        req_valid  [N];
    logic [31:0] req_addr   [N];
    logic        resp_ready [N];
    logic        flush      [N];
    logic        req_ready  [N];
    logic        resp_valid [N];
    logic [31:0] resp_instr [N];
    logic [31:0] resp_addr  [N];
    logic [1:0]  resp_fault [N];

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        imem_fetch_port #(
            .XLEN      (32),
            .DEPTH     (256),
            .LAT       ((g == 0) ? 1 : ((g == 1) ? 4 : 3)),
            .NOP_INSTR (32'h00000013)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_instr (resp_instr[g]),
            .resp_addr  (resp_addr[g]),
            .resp_fault (resp_fault[g]),
            .flush      (flush[g]),
            .prog_we    (prog_we),
            .prog_addr  (prog_addr),
            .prog_be    (prog_be),
            .prog_wdata (prog_wdata)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 3);
    endfunction

    // Transaction model: one outstanding fetch, cycles left before it shows.
    logic [31:0] m_mem   [N][256];
    bit          m_busy  [N];
    int          m_rem   [N];
    logic [31:0] m_instr [N];
    logic [31:0] m_addr  [N];
    logic [1:0]  m_fault [N];

    function automatic bit m_ready(int g);
        return !m_busy[g] || flush[g] || (m_rem[g] == 0 && resp_ready[g]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < N; g++) begin
                m_busy[g] = 1'b0;
                m_rem[g]  = 0;
            end
        end else begin
            for (int g = 0; g < N; g++) begin
                if (req_valid[g] && m_ready(g)) begin
                    m_busy[g] = 1'b1;
                    m_rem[g]  = lat_of(g) - 1;
                    m_addr[g] = req_addr[g];
                    if (req_addr[g][1:0] != 2'b00) begin
                        m_fault[g] = 2'b01;
                        m_instr[g] = 32'h00000013;
                    end else if (req_addr[g][31:10] != 22'd0) begin
                        m_fault[g] = 2'b10;
                        m_instr[g] = 32'h00000013;
                    end else begin
                        m_fault[g] = 2'b00;
                        m_instr[g] = m_mem[g][req_addr[g][9:2]];
                    end
                end else if (flush[g]) begin
                    m_busy[g] = 1'b0;
                end else if (m_busy[g]) begin
                    if (m_rem[g] > 0) m_rem[g] = m_rem[g] - 1;
                    else if (resp_ready[g]) m_busy[g] = 1'b0;
                end
            end
            if (prog_we) begin
                for (int g = 0; g < N; g++)
                    for (int b = 0; b < 4; b++)
                        if (prog_be[b]) m_mem[g][prog_addr][8*b +: 8] = prog_wdata[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && chk_en) begin
            for (int g = 0; g < N; g++) begin
                chk($sformatf("u%0d req_ready", g), req_ready[g], m_ready(g));
                chk($sformatf("u%0d resp_valid", g), resp_valid[g], m_busy[g] && m_rem[g] == 0);
                if (m_busy[g] && m_rem[g] == 0) begin
                    chk($sformatf("u%0d resp_instr", g), resp_instr[g], m_instr[g]);
                    chk($sformatf("u%0d resp_addr", g), resp_addr[g], m_addr[g]);
                    chk($sformatf("u%0d resp_fault", g), resp_fault[g], m_fault[g]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        prog_be    = be;
        step();
        prog_we    = 1'b0;
    endtask

    // Counts the accept cycle as 1; bounded so a missing response fails.
    task automatic wait_valid(input int g, output int cyc);
        cyc = 1;
        while (resp_valid[g] !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        rst_n      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_be    = '0;
        prog_wdata = '0;
        for (int g = 0; g < N; g++) begin
            req_valid[g]  = 1'b0;
            req_addr[g]   = '0;
            resp_ready[g] = 1'b0;
            flush[g]      = 1'b0;
        end
        step();
        step();
        for (int g = 0; g < N; g++) begin
            chk($sformatf("u%0d reset req_ready", g), req_ready[g], 1);
            chk($sformatf("u%0d reset resp_valid", g), resp_valid[g], 0);
            chk($sformatf("u%0d reset resp_instr", g), resp_instr[g], 0);
            chk($sformatf("u%0d reset resp_addr", g), resp_addr[g], 0);
            chk($sformatf("u%0d reset resp_fault", g), resp_fault[g], 0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;

        load(8'd0, 32'h00500093, 4'hF);
        load(8'd1, 32'h00A00113, 4'hF);
        load(8'd2, 32'h11111111, 4'hF);
        load(8'd3, 32'h00C00193, 4'hF);

        // LAT=1 back-to-back
        resp_ready[0] = 1'b1;
        req_valid[0]  = 1'b1;
        req_addr[0]   = 32'h0;
        step();
        chk("b2b first valid", resp_valid[0], 1);
        chk("b2b first instr", resp_instr[0], 32'h00500093);
        req_addr[0] = 32'h4;
        step();
        chk("b2b second valid", resp_valid[0], 1);
        chk("b2b second instr", resp_instr[0], 32'h00A00113);
        chk("b2b second fault", resp_fault[0], 2'b00);
        chk("b2b second addr", resp_addr[0], 32'h4);
        req_valid[0] = 1'b0;
        step();
        chk("b2b drained", resp_valid[0], 0);

        // LAT=4 with a stalled consumer
        resp_ready[1] = 1'b0;
        req_valid[1]  = 1'b1;
        req_addr[1]   = 32'h8;
        step();
        req_valid[1] = 1'b0;
        wait_valid(1, cyc);
        chk("lat4 latency", cyc, 4);
        chk("lat4 instr", resp_instr[1], 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lat4 stall valid", resp_valid[1], 1);
            chk("lat4 stall instr", resp_instr[1], 32'h11111111);
            chk("lat4 stall addr", resp_addr[1], 32'h8);
            chk("lat4 stall req_ready", req_ready[1], 0);
        end
        resp_ready[1] = 1'b1;
        #1;
        chk("lat4 ready on handshake", req_ready[1], 1);
        step();
        resp_ready[1] = 1'b0;
        chk("lat4 after handshake", resp_valid[1], 0);

        // Faults
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h6;
        step();
        chk("misalign fault", resp_fault[0], 2'b01);
        chk("misalign instr", resp_instr[0], 32'h00000013);
        req_addr[0] = 32'h400;
        step();
        chk("range fault", resp_fault[0], 2'b10);
        chk("range instr", resp_instr[0], 32'h00000013);
        req_valid[0] = 1'b0;
        step();

        // Same-edge write and fetch of word 2
        prog_we      = 1'b1;
        prog_addr    = 8'd2;
        prog_be      = 4'b0011;
        prog_wdata   = 32'hAAAAAAAA;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8;
        step();
        prog_we = 1'b0;
        chk("same-edge old data", resp_instr[0], 32'h11111111);
        step();
        chk("later fetch new data", resp_instr[0], 32'h1111AAAA);
        req_valid[0] = 1'b0;
        step();

        // LAT=3 flush in WAIT
        resp_ready[2] = 1'b0;
        req_valid[2]  = 1'b1;
        req_addr[2]   = 32'h0;
        step();
        req_valid[2] = 1'b0;
        step();
        flush[2] = 1'b1;
        step();
        flush[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid[2]) seen = 1'b1;
            step();
        end
        chk("flush wait no resp", seen, 0);

        // LAT=3 flush in RESP with a redirect request
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h4;
        step();
        req_valid[2] = 1'b0;
        wait_valid(2, cyc);
        chk("lat3 latency", cyc, 3);
        flush[2]     = 1'b1;
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'hC;
        step();
        flush[2]     = 1'b0;
        req_valid[2] = 1'b0;
        chk("flush resp dropped", resp_valid[2], 0);
        wait_valid(2, cyc);
        chk("redirect latency", cyc, 3);
        chk("redirect instr", resp_instr[2], 32'h00C00193);
        chk("redirect addr", resp_addr[2], 32'hC);
        resp_ready[2] = 1'b1;
        step();
        resp_ready[2] = 1'b0;

        // Asynchronous reset in WAIT, memory preserved
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_addr[1]   = 32'h4;
        step();
        req_valid[1] = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst resp_valid", resp_valid[1], 0);
        chk("async rst req_ready", req_ready[1], 1);
        chk("async rst resp_addr", resp_addr[1], 0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h0;
        step();
        req_valid[1] = 1'b0;
        wait_valid(1, cyc);
        chk("post-reset latency", cyc, 4);
        chk("post-reset instr", resp_instr[1], 32'h00500093);
        step();
        resp_ready[1] = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
